line_buffer: RTL and testbench
==============================

# line_buffer

Parametrised multi-line buffer for the median-filter datapath. It takes one pixel stream in raster order and stores the previous TAPS-1 lines in inferred block RAM. For every accepted pixel it emits a vertical column of TAPS pixels at the same x position: the current pixel plus the pixels 1..TAPS-1 lines above it. It sits between the pixel source and the window/sort stage, and generalises the single dual-port RAM to N lines with a runtime line length, frame restart and border masking.

## Interface
- DATA_W, 24, pixel width in bits
- ADDR_W, 11, line-address width; maximum line length is 2**ADDR_W
- TAPS, 3, column height (≥2); TAPS-1 line RAMs are instantiated
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- line_last  in  ADDR_W  line length minus 1; must be ≥1; sampled only when a pixel with in_sof is accepted
- in_valid  in  1  pixel accepted this cycle; no backpressure
- in_sof  in  1  qualifies in_valid; the pixel is column 0 of line 0 of a new frame
- in_data  in  DATA_W  pixel
- out_valid  out  1  output column valid; one pulse per accepted pixel
- out_col  out  TAPS*DATA_W  tap k at bits [k*DATA_W +: DATA_W]; tap 0 is the current pixel, tap k is k lines above
- out_mask  out  TAPS  bit k set if tap k holds real image data
- out_x  out  ADDR_W  column index of the output pixel
- out_sof  out  1  output pixel is frame column 0, line 0
- out_eol  out  1  output pixel is the last in its line

## Operation
- Internal state: column counter x, fill counter fill (0..TAPS-1, saturating), latched line_last_q, and TAPS-1 RAMs, each 2**ADDR_W × DATA_W with a registered read and no reset on contents.
- Accept with in_sof: the pixel uses x=0 and fill=0. Then line_last_q ← line_last, x ← 1, fill ← 0. This aborts any partial line.
- Accept without in_sof: the pixel uses the current x and fill.
  - If x == line_last_q: x ← 0 and fill ← min(fill+1, TAPS-1).
  - Otherwise: x ← x+1.
- Before the first in_sof after reset, line_last_q = 2**ADDR_W-1.
- Per accepted pixel at column x:
  - Read all RAMs at x.
  - One cycle later, write the delayed in_data into RAM 0 at the delayed x.
  - In the same cycle, write RAM k-1's read data into RAM k at the delayed x (shift down).
- Because line_last ≥1, consecutive reads and writes always target different addresses, so no bypass is needed. line_last=0 is unsupported.
- Output assembly: tap 0 is the delayed in_data; tap k is RAM k-1's read data. Tap k is forced to 0 and out_mask[k] is cleared when k > fill (fill as used for that pixel). out_mask[0] is always 1.
- in_valid low: no state changes, no RAM writes, out_valid=0. Data outputs hold their last value.
- rst_n low mid-line clears all counters and outputs. RAM contents survive but are masked, because fill=0.

## Timing
- Latency is 1 cycle: a pixel accepted at edge t gives out_valid=1 with out_col, out_mask, out_x, out_sof and out_eol valid after edge t+1.
- Throughput is one pixel per cycle sustained. Arbitrary gaps in in_valid are allowed.
- out_sof and out_eol are registered copies of in_sof and (x == line_last_q) at acceptance.
- Reset values:
  - out_valid, out_col, out_mask, out_x, out_sof, out_eol = 0
  - x = 0, fill = 0
  - line_last_q = all ones
- RAM writes occur on the cycle after acceptance. Reset asserted in that cycle suppresses the write.
- x wraps from line_last_q to 0. fill never exceeds TAPS-1.

## Test plan
Bench setting: DATA_W=8, ADDR_W=4, TAPS=3, line_last=3, pixel value = 16·row + col.

- **Reset:** hold rst_n=0 with in_valid toggling -> all outputs 0, no out_valid.
- **Full frame:** 4 lines, with in_sof on the first pixel -> required outputs:
  - row 0, col 2: out_col={0,0,0x02}, mask 3'b001
  - row 1, col 3: out_col={0,0x03,0x13}, mask 3'b011, out_eol=1
  - row 3, col 1: out_col={0x11,0x21,0x31}, mask 3'b111
- **Gapped input:** same frame with in_valid at 50% random duty -> identical output sequence; out_valid pulses only on the cycle after each acceptance.
- **Mid-line restart:** in_sof on a pixel arriving at x=2 in row 2 -> out_x=0, out_sof=1, mask 3'b001. The next line gives mask 3'b011.
- **Max length wrap:** line_last=15 latched with in_sof, 2 lines -> out_x runs 0..15 then 0, out_eol at x=15, and the second line's tap 1 equals the first line's pixels.
- **Async reset mid-line:** rst_n pulled low between edges at row 2 col 1 -> outputs go to 0 immediately without a clock edge. The following frame reproduces the full-frame results.

Source files
------------

// File: rtl/line_buffer.sv
// Multi-line buffer: stores the previous TAPS-1 lines in block RAM and emits a
// vertical column of TAPS pixels per accepted input pixel, masking unfilled rows.
module line_buffer #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 11,
   parameter int TAPS   = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_W-1:0]      line_last,
   input  logic                   in_valid,
   input  logic                   in_sof,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   output logic [TAPS*DATA_W-1:0] out_col,
   output logic [TAPS-1:0]        out_mask,
   output logic [ADDR_W-1:0]      out_x,
   output logic                   out_sof,
   output logic                   out_eol
);

   localparam int RAMS   = TAPS - 1;
   localparam int FILL_W = $clog2(TAPS);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAPS - 1);

   logic [ADDR_W-1:0]      x_q;
   logic [FILL_W-1:0]      fill_q;
   logic [ADDR_W-1:0]      line_last_q;
   logic [ADDR_W-1:0]      cur_x;
   logic [FILL_W-1:0]      cur_fill;
   logic                   at_eol;
   logic [TAPS-1:0]        mask_next;
   logic [DATA_W-1:0]      data_q;
   logic                   wr_en_q;
   logic [ADDR_W-1:0]      wr_x_q;
   logic [RAMS*DATA_W-1:0] rd_flat;
   logic [RAMS*DATA_W-1:0] wr_flat;

   // A start-of-frame pixel always lands at column 0 with an empty history.
   always_comb begin
      cur_x    = in_sof ? '0 : x_q;
      cur_fill = in_sof ? '0 : fill_q;
      at_eol   = (cur_x == line_last_q);
      for (int k = 0; k < TAPS; k++) begin
         mask_next[k] = (k <= int'(cur_fill));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q         <= '0;
         fill_q      <= '0;
         line_last_q <= '1;
      end else if (in_valid) begin
         if (in_sof) begin
            line_last_q <= line_last;
            x_q         <= ADDR_W'(1);
            fill_q      <= '0;
         end else if (at_eol) begin
            x_q <= '0;
            if (fill_q != FILL_MAX) begin
               fill_q <= fill_q + 1'b1;
            end
         end else begin
            x_q <= x_q + 1'b1;
         end
      end
   end

   // Output sideband plus the delayed write request that shifts lines down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_x_q    <= '0;
         data_q    <= '0;
         out_x     <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_mask  <= '0;
      end else begin
         out_valid <= in_valid;
         wr_en_q   <= in_valid;
         if (in_valid) begin
            wr_x_q   <= cur_x;
            data_q   <= in_data;
            out_x    <= cur_x;
            out_sof  <= in_sof;
            out_eol  <= at_eol;
            out_mask <= mask_next;
         end
      end
   end

   // RAM 0 takes the new pixel; every deeper RAM takes its neighbour's old line.
   always_comb begin
      wr_flat = '0;
      wr_flat[0 +: DATA_W] = data_q;
      for (int k = 1; k < RAMS; k++) begin
         wr_flat[k*DATA_W +: DATA_W] = rd_flat[(k-1)*DATA_W +: DATA_W];
      end
   end

   for (genvar g = 0; g < RAMS; g++) begin : g_ram
      logic [DATA_W-1:0] mem [2**ADDR_W];
      logic [DATA_W-1:0] rd_q;

      always_ff @(posedge clk) begin
         if (in_valid) begin
            rd_q <= mem[cur_x];
         end
         if (wr_en_q) begin
            mem[wr_x_q] <= wr_flat[g*DATA_W +: DATA_W];
         end
      end

      assign rd_flat[g*DATA_W +: DATA_W] = rd_q;
   end

   always_comb begin
      out_col = '0;
      out_col[0 +: DATA_W] = data_q;
      for (int k = 1; k < TAPS; k++) begin
         out_col[k*DATA_W +: DATA_W] = out_mask[k] ? rd_flat[(k-1)*DATA_W +: DATA_W] : '0;
      end
   end

endmodule

// File: tb/tb_line_buffer.sv
// Directed testbench for line_buffer: 4x4 frames with pixel = 16*row + col,
// covering reset, gaps, mid-line restart, max-length wrap and async reset.
module tb_line_buffer;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int TAPS   = 3;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [ADDR_W-1:0]      line_last;
   logic                   in_valid;
   logic                   in_sof;
   logic [DATA_W-1:0]      in_data;
   logic                   out_valid;
   logic [TAPS*DATA_W-1:0] out_col;
   logic [TAPS-1:0]        out_mask;
   logic [ADDR_W-1:0]      out_x;
   logic                   out_sof;
   logic                   out_eol;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   line_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAPS(TAPS)) dut (
      .clk(clk), .rst_n(rst_n), .line_last(line_last),
      .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_valid(out_valid), .out_col(out_col), .out_mask(out_mask),
      .out_x(out_x), .out_sof(out_sof), .out_eol(out_eol)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives one cycle of input; returns 1 time unit after the capturing edge.
   task automatic applyStimulus(input logic valid, input logic sof, input logic [7:0] data);
      in_valid = valid;
      in_sof   = sof;
      in_data  = data;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   function automatic logic [23:0] expCol(input int r, input int c);
      logic [23:0] v = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (k <= r) v[k*8 +: 8] = 8'(16*(r-k) + c);
      end
      return v;
   endfunction

   function automatic logic [2:0] expMask(input int r);
      return (r == 0) ? 3'b001 : (r == 1) ? 3'b011 : 3'b111;
   endfunction

   task automatic checkZero(input string tag);
      checkOutput({tag, " valid"}, 32'(out_valid), 0);
      checkOutput({tag, " col"},   32'(out_col),   0);
      checkOutput({tag, " mask"},  32'(out_mask),  0);
      checkOutput({tag, " x"},     32'(out_x),     0);
      checkOutput({tag, " sof"},   32'(out_sof),   0);
      checkOutput({tag, " eol"},   32'(out_eol),   0);
   endtask

   // Streams a 4x4 frame up to and including pixel (stopR, stopC).
   task automatic runFrame(input bit gapped, input int stopR, input int stopC);
      string t;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (r > stopR || (r == stopR && c > stopC)) return;
            if (gapped) begin
               for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++) begin
                  applyStimulus(1'b0, 1'b0, 8'h00);
                  checkOutput("gap valid", 32'(out_valid), 0);
               end
            end
            applyStimulus(1'b1, (r == 0 && c == 0), 8'(16*r + c));
            t = $sformatf("r%0d c%0d", r, c);
            checkOutput({t, " valid"}, 32'(out_valid), 1);
            checkOutput({t, " x"},     32'(out_x),     32'(c));
            checkOutput({t, " sof"},   32'(out_sof),   32'(r == 0 && c == 0));
            checkOutput({t, " eol"},   32'(out_eol),   32'(c == 3));
            checkOutput({t, " mask"},  32'(out_mask),  32'(expMask(r)));
            checkOutput({t, " col"},   32'(out_col),   32'(expCol(r, c)));
            if (r == 0 && c == 2) checkOutput("r0c2 const col", 32'(out_col), 32'h000002);
            if (r == 1 && c == 3) checkOutput("r1c3 const col", 32'(out_col), 32'h000313);
            if (r == 3 && c == 1) checkOutput("r3c1 const col", 32'(out_col), 32'h112131);
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      line_last = 4'd3;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_data   = '0;

      for (int i = 0; i < 4; i++) begin
         applyStimulus(i[0], i[1], 8'hAA);
         checkZero("reset");
      end
      @(negedge clk);
      rst_n = 1'b1;

      runFrame(1'b0, 3, 3);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("idle valid", 32'(out_valid), 0);
      checkOutput("idle hold col", 32'(out_col), 32'h132333);

      runFrame(1'b1, 3, 3);

      // Restart in the middle of row 2.
      runFrame(1'b0, 2, 1);
      applyStimulus(1'b1, 1'b1, 8'hA0);
      checkOutput("restart x",    32'(out_x),    0);
      checkOutput("restart sof",  32'(out_sof),  1);
      checkOutput("restart mask", 32'(out_mask), 32'b001);
      checkOutput("restart col",  32'(out_col),  32'h0000A0);
      for (int c = 1; c < 4; c++) begin
         applyStimulus(1'b1, 1'b0, 8'(8'hA0 + c));
         checkOutput("restart run x",   32'(out_x),   32'(c));
         checkOutput("restart run eol", 32'(out_eol), 32'(c == 3));
      end
      applyStimulus(1'b1, 1'b0, 8'hB0);
      checkOutput("after restart x",    32'(out_x),    0);
      checkOutput("after restart mask", 32'(out_mask), 32'b011);
      checkOutput("after restart col",  32'(out_col),  32'h00A0B0);

      // Maximum line length.
      line_last = 4'd15;
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, (r == 0 && c == 0), 8'(16*r + c));
            checkOutput("wrap x",   32'(out_x),   32'(c));
            checkOutput("wrap eol", 32'(out_eol), 32'(c == 15));
            if (r == 1) begin
               checkOutput("wrap mask", 32'(out_mask),     32'b011);
               checkOutput("wrap tap1", 32'(out_col[15:8]), 32'(c));
            end
         end
      end
      applyStimulus(1'b1, 1'b0, 8'h20);
      checkOutput("wrap next x",    32'(out_x),    0);
      checkOutput("wrap next mask", 32'(out_mask), 32'b111);
      checkOutput("wrap next col",  32'(out_col),  32'h001020);
      line_last = 4'd3;

      // Asynchronous reset between edges.
      runFrame(1'b0, 2, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkZero("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      runFrame(1'b0, 3, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
